// File: rtl/cpu_pkg.sv
// Shared CPU decode definitions: opcodes, immediate extension modes, issue FSM states.
// Opcode classification helpers are pure functions of the 6-bit op field.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_UPPER} ext_mode_t;

  typedef enum logic {ST_RUN, ST_LU_BUBBLE} issue_state_t;

  function automatic ext_mode_t ext_mode_of(input logic [5:0] op);
    if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) return EXT_ZERO;
    if (op == OP_LUI) return EXT_UPPER;
    return EXT_SIGN;
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic uses_rs(input logic [5:0] op);
    return !((op == OP_LUI) || (op == OP_J) || (op == OP_JAL));
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/imm_extend.sv
// Immediate extender: sign, zero or upper placement of a 16-bit immediate.
// Purely combinational, no latency, no flow control.
module imm_extend
  import cpu_pkg::*;
(
  input  logic [15:0] imm,
  input  ext_mode_t   ext_mode,
  output logic [31:0] imm_ext
);

  always_comb begin
    imm_ext = {{16{imm[15]}}, imm};
    case (ext_mode)
      EXT_ZERO:  imm_ext = {16'h0000, imm};
      EXT_UPPER: imm_ext = {imm, 16'h0000};
      default:   imm_ext = {{16{imm[15]}}, imm};
    endcase
  end

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue control: IF/ID and ID/EX slots, load-use bubble insertion, flush.
// One cycle ID->EX; fetch held via combinational if_stall on EX back-pressure or hazard.
module id_issue_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  output logic             if_stall,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [31:0]      ex_instr,
  output logic [31:0]      ex_imm,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic         id_valid;
  logic [31:0]  id_instr;
  issue_state_t state;

  logic [5:0]  id_op;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [5:0]  ex_op;
  logic [4:0]  ex_rt;
  logic [31:0] id_imm;
  logic        ex_adv;
  logic        hazard;

  assign id_op = id_instr[31:26];
  assign id_rs = id_instr[25:21];
  assign id_rt = id_instr[20:16];
  assign ex_op = ex_instr[31:26];
  assign ex_rt = ex_instr[20:16];

  imm_extend u_imm_extend (
    .imm      (id_instr[15:0]),
    .ext_mode (ext_mode_of(id_op)),
    .imm_ext  (id_imm)
  );

  assign ex_adv = !ex_valid || ex_ready;

  // A load writing $0 never creates a dependency.
  assign hazard = id_valid && ex_valid && is_load(ex_op) && (ex_rt != 5'd0) &&
                  ((uses_rs(id_op) && (id_rs == ex_rt)) ||
                   (uses_rt(id_op) && (id_rt == ex_rt)));

  assign if_stall = id_valid && (!ex_adv || hazard);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      id_valid   <= 1'b0;
      id_instr   <= 32'h0;
      ex_valid   <= 1'b0;
      ex_instr   <= 32'h0;
      ex_imm     <= 32'h0;
      bubble_cnt <= '0;
    end else if (flush) begin
      state    <= ST_RUN;
      id_valid <= 1'b0;
      ex_valid <= 1'b0;
    end else if (state == ST_RUN && ex_adv && hazard) begin
      state    <= ST_LU_BUBBLE;
      ex_valid <= 1'b0;
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else begin
      // In LU_BUBBLE the EX slot is empty, so the hazard cannot hold and ID advances.
      state <= ST_RUN;
      if (ex_adv) begin
        ex_valid <= id_valid;
        ex_instr <= id_instr;
        ex_imm   <= id_imm;
        id_valid <= if_valid;
        if (if_valid) id_instr <= if_instr;
      end
    end
  end

endmodule
